// File: rtl/w0rm_peripheral_memory_arbiter.sv
// ---------------------------------------------------------------------------------------------
// w0rm_peripheral_memory_arbiter
//
// Shares the single port A of a W0RM_Peripheral_MemoryBlock between two bus masters (for
// example instruction fetch and load/store) using round-robin arbitration.
//
// Each forwarded request is tagged with the ID of the requester that issued it. The ID sits in
// the MSB of the memory-side user field. The memory returns the user field with its response,
// and the arbiter uses that bit to steer the response back to the issuing port.
//
// Latency is fixed:
//   - A request accepted at edge T is presented to the memory during cycle T..T+1.
//   - The memory registers it at edge T+1.
//   - The response strobe is visible during cycle T+2..T+3.
// One request can be accepted every cycle.
//
// Ports
//   mem_clk, mem_reset        clock (rising edge) and asynchronous active-high reset
//   pN_valid_i .. pN_user_i   request channel of requester N (N = 0, 1); payload is held
//                             stable by the requester until accepted
//   pN_ready_o                request accepted this cycle when pN_valid_i && pN_ready_o
//   pN_valid_o                one-cycle response strobe to requester N
//   pN_data_o, pN_user_o      response data / returned sideband; hold until the next response
//   mem_valid_o .. mem_user_o registered request towards memory port A; user = {id, user}
//   mem_valid_i .. mem_user_i registered response from memory port A
// ---------------------------------------------------------------------------------------------
module w0rm_peripheral_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 32
) (
    input  logic                  mem_clk,
    input  logic                  mem_reset,

    // Requester 0
    input  logic                  p0_valid_i,
    input  logic                  p0_read_i,
    input  logic                  p0_write_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_data_i,
    input  logic [USER_WIDTH-1:0] p0_user_i,
    output logic                  p0_ready_o,
    output logic                  p0_valid_o,
    output logic [DATA_WIDTH-1:0] p0_data_o,
    output logic [USER_WIDTH-1:0] p0_user_o,

    // Requester 1
    input  logic                  p1_valid_i,
    input  logic                  p1_read_i,
    input  logic                  p1_write_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_data_i,
    input  logic [USER_WIDTH-1:0] p1_user_i,
    output logic                  p1_ready_o,
    output logic                  p1_valid_o,
    output logic [DATA_WIDTH-1:0] p1_data_o,
    output logic [USER_WIDTH-1:0] p1_user_o,

    // Memory port A request
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [USER_WIDTH:0]   mem_user_o,

    // Memory port A response
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [USER_WIDTH:0]   mem_user_i
);

    // -----------------------------------------------------------------------------------------
    // Arbitration state and grant
    // -----------------------------------------------------------------------------------------

    // ID of the most recently accepted requester. It resets to 1 so that port 0 wins the
    // first contention.
    logic last_r;

    logic grant_0;
    logic grant_1;
    logic accept;
    logic accept_id;
    logic forward;

    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        case ({p1_valid_i, p0_valid_i})
            2'b01: grant_0 = 1'b1;
            2'b10: grant_1 = 1'b1;
            // On contention, the requester that was not served last goes next.
            2'b11: begin
                if (last_r) begin
                    grant_0 = 1'b1;
                end else begin
                    grant_1 = 1'b1;
                end
            end
            default: begin
                grant_0 = 1'b0;
                grant_1 = 1'b0;
            end
        endcase
    end

    // Ready is gated by reset, so nothing is accepted while reset is asserted. Pending
    // requests stay with their requesters and are re-arbitrated after release.
    assign p0_ready_o = grant_0 && !mem_reset;
    assign p1_ready_o = grant_1 && !mem_reset;

    assign accept    = (p0_valid_i && p0_ready_o) || (p1_valid_i && p1_ready_o);
    assign accept_id = grant_1;

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= accept_id;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Selected request payload
    // -----------------------------------------------------------------------------------------

    logic                  sel_read;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;

    always_comb begin
        sel_read  = p0_read_i;
        sel_write = p0_write_i;
        sel_addr  = p0_addr_i;
        sel_data  = p0_data_i;
        sel_user  = p0_user_i;
        if (grant_1) begin
            sel_read  = p1_read_i;
            sel_write = p1_write_i;
            sel_addr  = p1_addr_i;
            sel_data  = p1_data_i;
            sel_user  = p1_user_i;
        end
    end

    // A no-op request (neither read nor write) is consumed here. It still counts for
    // round-robin, but the memory never sees it, so no response will come back for it.
    assign forward = accept && (sel_read || sel_write);

    // -----------------------------------------------------------------------------------------
    // Issue register towards memory port A
    // -----------------------------------------------------------------------------------------

    logic                  mem_valid_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [USER_WIDTH:0]   mem_user_q;

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            mem_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_user_q  <= '0;
        end else begin
            mem_valid_q <= forward;
            // Payload holds its last value while idle.
            if (forward) begin
                mem_read_q  <= sel_read;
                mem_write_q <= sel_write;
                mem_addr_q  <= sel_addr;
                mem_data_q  <= sel_data;
                mem_user_q  <= {accept_id, sel_user};
            end
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_user_o  = mem_user_q;

    // -----------------------------------------------------------------------------------------
    // Response window
    // -----------------------------------------------------------------------------------------

    // expect_r is high exactly in the cycle where the memory response for last cycle's issue
    // may appear. A memory valid outside this window is stale or spurious and is dropped.
    // This also discards in-flight responses across a reset. An out-of-range access gets no
    // memory valid, so the window simply expires.
    logic expect_r;

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            expect_r <= 1'b0;
        end else begin
            expect_r <= mem_valid_q;
        end
    end

    logic resp_hit;
    logic resp_id;

    assign resp_hit = mem_valid_i && expect_r;
    assign resp_id  = mem_user_i[USER_WIDTH];

    // -----------------------------------------------------------------------------------------
    // Response capture and routing
    // -----------------------------------------------------------------------------------------

    logic                  p0_valid_q;
    logic [DATA_WIDTH-1:0] p0_data_q;
    logic [USER_WIDTH-1:0] p0_user_q;
    logic                  p1_valid_q;
    logic [DATA_WIDTH-1:0] p1_data_q;
    logic [USER_WIDTH-1:0] p1_user_q;

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            p0_valid_q <= 1'b0;
            p0_data_q  <= '0;
            p0_user_q  <= '0;
        end else begin
            p0_valid_q <= resp_hit && !resp_id;
            if (resp_hit && !resp_id) begin
                p0_data_q <= mem_data_i;
                p0_user_q <= mem_user_i[USER_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
            p1_user_q  <= '0;
        end else begin
            p1_valid_q <= resp_hit && resp_id;
            if (resp_hit && resp_id) begin
                p1_data_q <= mem_data_i;
                p1_user_q <= mem_user_i[USER_WIDTH-1:0];
            end
        end
    end

    assign p0_valid_o = p0_valid_q;
    assign p0_data_o  = p0_data_q;
    assign p0_user_o  = p0_user_q;
    assign p1_valid_o = p1_valid_q;
    assign p1_data_o  = p1_data_q;
    assign p1_user_o  = p1_user_q;

endmodule

// File: tb/tb_w0rm_peripheral_memory_arbiter.sv
// ---------------------------------------------------------------------------------------------
// Testbench for w0rm_peripheral_memory_arbiter.
//
// A small behavioural model of memory port A sits behind the arbiter:
//   - registered response, 16 words starting at BASE;
//   - valid is returned for in-range reads and writes;
//   - no valid is returned for out-of-range addresses.
//
// Expected responses are pushed per port when a request is driven and is expected to be
// accepted. A monitor pops them when a response strobe appears.
// ---------------------------------------------------------------------------------------------
module tb_w0rm_peripheral_memory_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] LIMIT = 32'h0000_1040;
    localparam int          DEPTH = 16;

    logic        mem_clk = 1'b0;
    logic        mem_reset;

    logic        p0_valid_i, p0_read_i, p0_write_i;
    logic [31:0] p0_addr_i, p0_data_i, p0_user_i;
    logic        p0_ready_o, p0_valid_o;
    logic [31:0] p0_data_o, p0_user_o;

    logic        p1_valid_i, p1_read_i, p1_write_i;
    logic [31:0] p1_addr_i, p1_data_i, p1_user_i;
    logic        p1_ready_o, p1_valid_o;
    logic [31:0] p1_data_o, p1_user_o;

    logic        mem_valid_o, mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [32:0] mem_user_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic [32:0] mem_user_i;

    always #5 mem_clk = ~mem_clk;

    w0rm_peripheral_memory_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .USER_WIDTH(32)
    ) dut (
        .mem_clk    (mem_clk),
        .mem_reset  (mem_reset),
        .p0_valid_i (p0_valid_i),
        .p0_read_i  (p0_read_i),
        .p0_write_i (p0_write_i),
        .p0_addr_i  (p0_addr_i),
        .p0_data_i  (p0_data_i),
        .p0_user_i  (p0_user_i),
        .p0_ready_o (p0_ready_o),
        .p0_valid_o (p0_valid_o),
        .p0_data_o  (p0_data_o),
        .p0_user_o  (p0_user_o),
        .p1_valid_i (p1_valid_i),
        .p1_read_i  (p1_read_i),
        .p1_write_i (p1_write_i),
        .p1_addr_i  (p1_addr_i),
        .p1_data_i  (p1_data_i),
        .p1_user_i  (p1_user_i),
        .p1_ready_o (p1_ready_o),
        .p1_valid_o (p1_valid_o),
        .p1_data_o  (p1_data_o),
        .p1_user_o  (p1_user_o),
        .mem_valid_o(mem_valid_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_user_o (mem_user_o),
        .mem_valid_i(mem_valid_i),
        .mem_data_i (mem_data_i),
        .mem_user_i (mem_user_i)
    );

    // ---------------------------------------------------------------- memory port A model
    logic [31:0] mem [DEPTH];
    logic        mem_init;
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge mem_clk) begin
        mem_valid_i <= 1'b0;
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_valid_o && mem_addr_o >= BASE && mem_addr_o < LIMIT) begin
            mem_valid_i <= 1'b1;
            mem_user_i  <= mem_user_o;
            mem_data_i  <= mem[mem_addr_o[5:2]];
            if (mem_write_o) mem[mem_addr_o[5:2]] <= mem_data_o;
        end
    end

    int cyc = 0;
    always @(posedge mem_clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic [31:0] data;
        logic [31:0] user;
        bit          dc;    // data is don't-care (write response)
        int          due;   // cyc value in which the strobe must be visible
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] shadow [DEPTH];
    int          vectors;
    int          miscompares;

    // Called at negedge+1 just before the accepting edge: the strobe is due 2 edges after it.
    task automatic push_exp(input bit port, input logic [31:0] data, input logic [31:0] user,
                            input bit dc);
        exp_t e;
        e.data = data;
        e.user = user;
        e.dc   = dc;
        e.due  = cyc + 3;
        if (port) q1.push_back(e);
        else      q0.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge mem_clk);
            if (q0.size() != 0 && q0[0].due < cyc) begin
                e = q0.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL p0_missing_resp: no strobe by cycle %0d, required user %h",
                         e.due, e.user);
            end
            if (q1.size() != 0 && q1[0].due < cyc) begin
                e = q1.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL p1_missing_resp: no strobe by cycle %0d, required user %h",
                         e.due, e.user);
            end
            if (p0_valid_o !== 1'b0) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL p0_unexpected_resp: valid=%b at cycle %0d, required none",
                             p0_valid_o, cyc);
                end else begin
                    e = q0.pop_front();
                    if (e.due != cyc || p0_user_o !== e.user || (!e.dc && p0_data_o !== e.data))
                    begin
                        miscompares++;
                        $display("FAIL p0_resp: got cycle %0d data %h user %h, required cycle %0d data %h user %h",
                                 cyc, p0_data_o, p0_user_o, e.due, e.data, e.user);
                    end
                end
            end
            if (p1_valid_o !== 1'b0) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL p1_unexpected_resp: valid=%b at cycle %0d, required none",
                             p1_valid_o, cyc);
                end else begin
                    e = q1.pop_front();
                    if (e.due != cyc || p1_user_o !== e.user || (!e.dc && p1_data_o !== e.data))
                    begin
                        miscompares++;
                        $display("FAIL p1_resp: got cycle %0d data %h user %h, required cycle %0d data %h user %h",
                                 cyc, p1_data_o, p1_user_o, e.due, e.data, e.user);
                    end
                end
            end
        end
    endtask

    // ---------------------------------------------------------------- stimulus helpers
    task automatic idle_inputs();
        p0_valid_i = 1'b0; p0_read_i = 1'b0; p0_write_i = 1'b0;
        p1_valid_i = 1'b0; p1_read_i = 1'b0; p1_write_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_idx = 4'(idx);
        pre_val = val;
        pre_en  = 1'b1;
        @(negedge mem_clk);
        pre_en = 1'b0;
        shadow[idx] = val;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        mem_reset = 1'b1;
        mem_init  = 1'b1;
        pre_en    = 1'b0;
        pre_idx   = 4'd0;
        pre_val   = 32'd0;
        idle_inputs();
        p0_addr_i = 32'd0; p0_data_i = 32'd0; p0_user_i = 32'd0;
        p1_addr_i = 32'd0; p1_data_i = 32'd0; p1_user_i = 32'd0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hA500_0000 + 32'(i);
        // Requests present during reset must not be accepted.
        p0_valid_i = 1'b1; p0_read_i = 1'b1;
        p1_valid_i = 1'b1; p1_read_i = 1'b1;
        @(negedge mem_clk);
        mem_init = 1'b0;
        @(negedge mem_clk);
        #1;
        vectors++;
        if ({p0_ready_o, p1_ready_o, p0_valid_o, p1_valid_o, mem_valid_o, mem_read_o,
             mem_write_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: rdy %b%b vld %b%b mem v/r/w %b%b%b, required all 0",
                     p0_ready_o, p1_ready_o, p0_valid_o, p1_valid_o, mem_valid_o, mem_read_o,
                     mem_write_o);
        end
        vectors++;
        if ({p0_data_o, p0_user_o, p1_data_o, p1_user_o, mem_addr_o, mem_data_o, mem_user_o}
            !== 225'd0) begin
            miscompares++;
            $display("FAIL reset_data: p0 %h/%h p1 %h/%h mem %h/%h/%h, required all 0",
                     p0_data_o, p0_user_o, p1_data_o, p1_user_o, mem_addr_o, mem_data_o,
                     mem_user_o);
        end
        idle_inputs();
        mem_reset = 1'b0;
        #1;
        vectors++;
        if ({p0_ready_o, p1_ready_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_grant: ready %b%b, required 00", p0_ready_o, p1_ready_o);
        end
        @(negedge mem_clk);
    endtask

    task automatic test_contention();
        int k0 = 0;
        int k1 = 0;
        for (int i = 0; i < 6; i++) begin
            p0_valid_i = 1'b1; p0_read_i = 1'b1; p0_write_i = 1'b0;
            p0_addr_i  = BASE + 32'(4 * k0);
            p0_user_i  = 32'h100 + 32'(k0);
            p1_valid_i = 1'b1; p1_read_i = 1'b1; p1_write_i = 1'b0;
            p1_addr_i  = BASE + 32'(4 * (8 + k1));
            p1_user_i  = 32'h200 + 32'(k1);
            #1;
            vectors++;
            if ((i % 2) == 0) begin
                if ({p1_ready_o, p0_ready_o} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL contention_grant[%0d]: ready p1p0=%b%b, required 01",
                             i, p1_ready_o, p0_ready_o);
                end
                push_exp(1'b0, shadow[k0], p0_user_i, 1'b0);
                k0++;
            end else begin
                if ({p1_ready_o, p0_ready_o} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL contention_grant[%0d]: ready p1p0=%b%b, required 10",
                             i, p1_ready_o, p0_ready_o);
                end
                push_exp(1'b1, shadow[8 + k1], p1_user_i, 1'b0);
                k1++;
            end
            @(negedge mem_clk);
        end
        idle_inputs();
        wait_cycles(5);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL contention_drain: %0d/%0d pending, required 0/0", q0.size(),
                     q1.size());
        end
    endtask

    task automatic test_single_read();
        preload(3, 32'hDEAD_BEEF);
        p0_valid_i = 1'b1; p0_read_i = 1'b1; p0_write_i = 1'b0;
        p0_addr_i  = BASE + 32'd12;
        p0_user_i  = 32'h55;
        #1;
        vectors++;
        if ({p1_ready_o, p0_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ready: ready p1p0=%b%b, required 01", p1_ready_o, p0_ready_o);
        end
        push_exp(1'b0, 32'hDEAD_BEEF, 32'h55, 1'b0);
        @(negedge mem_clk);
        idle_inputs();
        vectors++;
        if (mem_valid_o !== 1'b1 || mem_read_o !== 1'b1 || mem_write_o !== 1'b0 ||
            mem_addr_o !== BASE + 32'd12 || mem_user_o !== {1'b0, 32'h55}) begin
            miscompares++;
            $display("FAIL single_issue: v/r/w %b%b%b addr %h user %h, required 110 %h %h",
                     mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_user_o,
                     BASE + 32'd12, {1'b0, 32'h55});
        end
        @(negedge mem_clk);
        vectors++;
        if (mem_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_issue_drop: mem_valid_o=%b, required 0", mem_valid_o);
        end
        wait_cycles(3);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain: %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_back_to_back();
        // p1 writes, then p0 reads the same word on the very next cycle.
        p1_valid_i = 1'b1; p1_read_i = 1'b0; p1_write_i = 1'b1;
        p1_addr_i  = BASE + 32'd4;
        p1_data_i  = 32'h1234_5678;
        p1_user_i  = 32'h77;
        #1;
        vectors++;
        if ({p1_ready_o, p0_ready_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL write_ready: ready p1p0=%b%b, required 10", p1_ready_o, p0_ready_o);
        end
        push_exp(1'b1, 32'd0, 32'h77, 1'b1);
        shadow[1] = 32'h1234_5678;
        @(negedge mem_clk);
        p1_valid_i = 1'b0; p1_write_i = 1'b0;
        p0_valid_i = 1'b1; p0_read_i = 1'b1; p0_write_i = 1'b0;
        p0_addr_i  = BASE + 32'd4;
        p0_user_i  = 32'h66;
        #1;
        vectors++;
        if (mem_write_o !== 1'b1 || mem_data_o !== 32'h1234_5678 ||
            mem_user_o !== {1'b1, 32'h77}) begin
            miscompares++;
            $display("FAIL write_issue: write %b data %h user %h, required 1 12345678 %h",
                     mem_write_o, mem_data_o, mem_user_o, {1'b1, 32'h77});
        end
        vectors++;
        if ({p1_ready_o, p0_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL readback_ready: ready p1p0=%b%b, required 01", p1_ready_o,
                     p0_ready_o);
        end
        push_exp(1'b0, 32'h1234_5678, 32'h66, 1'b0);
        @(negedge mem_clk);
        idle_inputs();
        wait_cycles(4);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL readback_drain: %0d/%0d pending, required 0/0", q0.size(),
                     q1.size());
        end
    endtask

    task automatic test_noop_oor();
        // No-op: accepted but never forwarded.
        p0_valid_i = 1'b1; p0_read_i = 1'b0; p0_write_i = 1'b0;
        p0_addr_i  = BASE;
        p0_user_i  = 32'h9;
        #1;
        vectors++;
        if (p0_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL noop_ready: p0_ready_o=%b, required 1", p0_ready_o);
        end
        @(negedge mem_clk);
        idle_inputs();
        vectors++;
        if (mem_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL noop_issue: mem_valid_o=%b, required 0", mem_valid_o);
        end
        // Out-of-range read: forwarded, but the memory never answers.
        p1_valid_i = 1'b1; p1_read_i = 1'b1; p1_write_i = 1'b0;
        p1_addr_i  = BASE - 32'd4;
        p1_user_i  = 32'hAB;
        #1;
        vectors++;
        if (p1_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_ready: p1_ready_o=%b, required 1", p1_ready_o);
        end
        @(negedge mem_clk);
        idle_inputs();
        vectors++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== BASE - 32'd4) begin
            miscompares++;
            $display("FAIL oor_issue: mem_valid_o=%b addr %h, required 1 %h", mem_valid_o,
                     mem_addr_o, BASE - 32'd4);
        end
        wait_cycles(5);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL noop_oor_drain: %0d/%0d pending, required 0/0", q0.size(),
                     q1.size());
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            p1_valid_i = 1'b1; p1_read_i = 1'b1; p1_write_i = 1'b0;
            p1_addr_i  = BASE + 32'(4 * (4 + i));
            p1_user_i  = 32'h300 + 32'(i);
            #1;
            vectors++;
            if (p1_ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready[%0d]: p1_ready_o=%b, required 1", i, p1_ready_o);
            end
            push_exp(1'b1, shadow[4 + i], p1_user_i, 1'b0);
            @(negedge mem_clk);
        end
        idle_inputs();
        wait_cycles(5);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL stream_drain: %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_reset_midflight();
        // Make port 1 the last winner so the post-reset grant to port 0 comes from reset.
        p1_valid_i = 1'b1; p1_read_i = 1'b0; p1_write_i = 1'b0;
        @(negedge mem_clk);
        idle_inputs();
        p0_valid_i = 1'b1; p0_read_i = 1'b1; p0_write_i = 1'b0;
        p0_addr_i  = BASE + 32'd8;
        p0_user_i  = 32'h11;
        #1;
        vectors++;
        if (p0_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flight_ready: p0_ready_o=%b, required 1", p0_ready_o);
        end
        // No expectation pushed: this response must be discarded.
        @(negedge mem_clk);
        idle_inputs();
        @(posedge mem_clk);
        #2;
        mem_reset = 1'b1;
        #1;
        vectors++;
        if ({p0_ready_o, p1_ready_o, p0_valid_o, p1_valid_o, mem_valid_o, mem_read_o,
             mem_write_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL flight_reset_ctrl: rdy %b%b vld %b%b mem v/r/w %b%b%b, required all 0",
                     p0_ready_o, p1_ready_o, p0_valid_o, p1_valid_o, mem_valid_o, mem_read_o,
                     mem_write_o);
        end
        vectors++;
        if ({p0_data_o, p0_user_o, p1_data_o, p1_user_o, mem_addr_o, mem_data_o, mem_user_o}
            !== 225'd0) begin
            miscompares++;
            $display("FAIL flight_reset_data: p0 %h/%h p1 %h/%h mem %h/%h/%h, required all 0",
                     p0_data_o, p0_user_o, p1_data_o, p1_user_o, mem_addr_o, mem_data_o,
                     mem_user_o);
        end
        p0_valid_i = 1'b1; p0_read_i = 1'b1; p0_addr_i = BASE;         p0_user_i = 32'h21;
        p1_valid_i = 1'b1; p1_read_i = 1'b1; p1_addr_i = BASE + 32'd32; p1_user_i = 32'h31;
        #1;
        vectors++;
        if ({p1_ready_o, p0_ready_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flight_reset_hold: ready p1p0=%b%b, required 00", p1_ready_o,
                     p0_ready_o);
        end
        wait_cycles(2);
        mem_reset = 1'b0;
        #1;
        vectors++;
        if ({p1_ready_o, p0_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset_grant: ready p1p0=%b%b, required 01", p1_ready_o,
                     p0_ready_o);
        end
        push_exp(1'b0, shadow[0], 32'h21, 1'b0);
        @(negedge mem_clk);
        p0_valid_i = 1'b0;
        #1;
        vectors++;
        if (p1_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_p1: p1_ready_o=%b, required 1", p1_ready_o);
        end
        push_exp(1'b1, shadow[8], 32'h31, 1'b0);
        @(negedge mem_clk);
        idle_inputs();
        wait_cycles(5);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL flight_drain: %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_contention();
        test_single_read();
        test_back_to_back();
        test_noop_oor();
        test_streaming();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/w0rm_peripheral_memory_arbiter.md
# w0rm_peripheral_memory_arbiter

Two-requester round-robin arbiter that shares the single port A of a `W0RM_Peripheral_MemoryBlock` instance between two bus masters, e.g. instruction fetch and load/store. Each requester has a valid/ready request channel and a registered response channel. The arbiter tags each forwarded request with the requester ID in the memory user field and routes the memory's response back to the issuing port. Fixed 3-cycle accept-to-response latency, one request per cycle throughput.

## Interface
- `ADDR_WIDTH`, 32, address width on requester and memory sides
- `DATA_WIDTH`, 32, data width
- `USER_WIDTH`, 32, requester sideband width; memory-side user width is `USER_WIDTH+1`

One clock; reset is asynchronous and active-high. Ports:
- `mem_clk` in 1: clock; all state updates on rising edge
- `mem_reset` in 1: asynchronous active-high reset
- `pN_valid_i` in 1 (N=0,1): request present; held with payload stable until accepted
- `pN_read_i`, `pN_write_i` in 1: operation type
- `pN_addr_i` in `ADDR_WIDTH`: address
- `pN_data_i` in `DATA_WIDTH`: write data
- `pN_user_i` in `USER_WIDTH`: sideband, returned with response
- `pN_ready_o` out 1: request accepted this cycle when `pN_valid_i && pN_ready_o`
- `pN_valid_o` out 1: one-cycle response strobe
- `pN_data_o` out `DATA_WIDTH`: response data
- `pN_user_o` out `USER_WIDTH`: returned sideband
- `mem_valid_o`, `mem_read_o`, `mem_write_o` out 1: to memory `mem_a_valid_i/read_i/write_i`
- `mem_addr_o` out `ADDR_WIDTH`, `mem_data_o` out `DATA_WIDTH`: to memory address/data
- `mem_user_o` out `USER_WIDTH+1`: `{id, pN_user_i}`, id in MSB
- `mem_valid_i` in 1, `mem_data_i` in `DATA_WIDTH`, `mem_user_i` in `USER_WIDTH+1`: memory response

## Operation
- **Grant (combinational):**
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to `last_r` is granted.
  - `pN_ready_o = grant_N && !mem_reset`.
  - No port valid: no grant.
- **last_r:**
  - Resets to 1, so port 0 wins the first contention.
  - Updates to the granted ID on every accept.
- **Issue (registered):**
  - On accept with `read|write` set, the next cycle drives `mem_valid_o=1` and copies read/write/addr/data into the `mem_*` outputs.
  - `mem_user_o = {id, user}`.
  - `mem_valid_o` is deasserted in any cycle with no accept.
  - Payload registers hold their last value when idle.
- **No-op request** (`read=write=0`): accepted (ready high, `last_r` updated) but not forwarded. `mem_valid_o` stays 0 and no response is ever produced.
- **expect_r:**
  - Loads `mem_valid_o` every cycle.
  - Marks the cycle in which a memory response is legal.
- **Response capture:**
  - Occurs when `mem_valid_i && expect_r`.
  - The port selected by `mem_user_i[USER_WIDTH]` gets `pN_valid_o=1` for one cycle, with `pN_data_o <= mem_data_i` and `pN_user_o <= mem_user_i[USER_WIDTH-1:0]`.
  - The other port's `valid_o` is 0.
  - `mem_valid_i` without `expect_r` is ignored.
- **Out-of-range address:** the memory returns no valid. `expect_r` expires after one cycle and the requester receives no response. Requesters own any timeout handling.
- **Data hold:** `pN_data_o`/`pN_user_o` hold their value until the next response to that port.
- **Writes:** produce a response, because the memory asserts valid for writes. The data is memory's registered read data and is don't-care to the requester.

## Timing
- **Reset values:** all `*_valid_o`, `mem_read_o`, `mem_write_o`, `pN_ready_o` = 0. All data/addr/user outputs = 0. `last_r=1`, `expect_r=0`.
- **Latency:**
  - Accept at edge T.
  - `mem_valid_o` is high in cycle T..T+1.
  - The memory registers at edge T+1.
  - `pN_valid_o` is high in cycle T+2..T+3, i.e. response visible 2 cycles after the accept edge (3 cycles including the accept cycle).
- **Throughput:** one accept per cycle. Back-to-back accepts from one port produce back-to-back responses in order.
- **Contention:** both ports continuously valid yields accepts alternating 0,1,0,1…
- **Reset mid-operation:**
  - Asynchronously clears `expect_r`, so in-flight responses are discarded.
  - Holds ready low.
  - Pending requests remain with the requesters and are re-arbitrated after release, with port 0 first.

## Test plan
- **Single read:** preload word 3 = 0xDEADBEEF. p0 reads address BASE+12 with user 0x55, accepted at edge T. Required: `p0_valid_o` high exactly in cycle T+2 with data 0xDEADBEEF and user 0x55; `p1_valid_o` stays 0.
- **Contention:** both ports valid for 6 cycles with distinct addresses. Required: grants alternate 0,1,0,1,0,1, and each response arrives on the matching port with the correct user.
- **Write/read-back:** p1 writes 0x12345678 to BASE+4, then p0 reads BASE+4. Required: p0 data = 0x12345678.
- **No-op and out-of-range:**
  - p0 `valid` with `read=write=0`: accepted, `mem_valid_o` stays 0, no response.
  - p1 reads BASE−4: accepted, forwarded, no `p1_valid_o`.
- **Reset mid-flight:** assert `mem_reset` in cycle T+1 after an accept. Required: no `pN_valid_o`, all outputs 0 immediately, and the first post-reset contention grants port 0.
- **Streaming:** p1 alone, valid for 8 cycles. Required: ready high every cycle, and 8 consecutive response strobes in order.
